// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and types; the macro set mirrors the codebase's define.vh names.
`ifndef ResetPc
`define ResetPc 32'h0000_0000
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef Zero
`define Zero 32'h0000_0000
`endif
`ifndef Enabled
`define Enabled 1'b1
`endif
`ifndef Disabled
`define Disabled 1'b0
`endif

package if_stage_pkg;

  localparam logic [`InstAddrBus] RESET_PC  = `ResetPc;
  localparam logic [`InstAddrBus] ZERO_WORD = `Zero;
  localparam logic [`InstAddrBus] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits are simply dropped.
  function automatic logic [`InstAddrBus] word_align(input logic [`InstAddrBus] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst} pairs sitting between instruction memory and ID.
module fetch_buf
  import if_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [`InstAddrBus] push_pc,
  input  logic [`InstBus]     push_inst,
  output logic [`InstAddrBus] head_pc,
  output logic [`InstBus]     head_inst,
  output logic                full,
  output logic                empty,
  output logic [1:0]          count
);

  fetch_entry_t entries [2];
  fetch_entry_t head_entry;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, a same-edge pop frees the head slot, which the write pointer already targets.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      entries[wr_ptr] <= '{pc: push_pc, inst: push_inst};
    end
  end

  assign head_entry = entries[rd_ptr];
  assign head_pc    = head_entry.pc;
  assign head_inst  = head_entry.inst;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding a 2-deep buffer into IF/ID.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                br_i,
  input  logic [`InstAddrBus] bt_i,
  output logic                imem_req_o,
  output logic [`InstAddrBus] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [`InstBus]     imem_data_i,
  output logic [`InstAddrBus] pc_o,
  output logic [`InstBus]     inst_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [`InstAddrBus] fetch_pc;
  logic [`InstAddrBus] fetch_pc_nxt;
  logic [`InstAddrBus] addr_q;
  logic [`InstAddrBus] addr_nxt;
  logic [`InstAddrBus] pc_q;
  logic [`InstBus]     inst_q;

  logic                ack;
  logic                accept;
  logic                slot_free;
  logic                issue;
  logic                buf_pop;
  logic [1:0]          count_nxt;

  logic [`InstAddrBus] head_pc;
  logic [`InstBus]     head_inst;
  logic                buf_full;
  logic                buf_empty;
  logic [1:0]          buf_count;

  assign imem_req_o  = (state != IDLE);
  assign imem_addr_o = addr_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;

  assign ack     = imem_req_o && imem_ack_i;
  assign accept  = ack && (state == WAIT) && !br_i;
  assign buf_pop = !stall_i && !br_i && !buf_empty;

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (buf_pop),
    .flush     (br_i),
    .push_pc   (addr_q),
    .push_inst (imem_data_i),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Occupancy is looked at after this edge so a new request never overcommits the buffer.
  always_comb begin
    count_nxt    = br_i ? 2'd0 : (buf_count + {1'b0, accept} - {1'b0, buf_pop});
    fetch_pc_nxt = fetch_pc;
    if (br_i) begin
      fetch_pc_nxt = word_align(bt_i);
    end else if (accept) begin
      fetch_pc_nxt = fetch_pc + PC_STEP;
    end

    slot_free = (state == IDLE) || ack;
    issue     = slot_free && (count_nxt < 2'd2) && !buf_full_after_flush(buf_full, br_i, buf_pop);
    state_nxt = state;
    addr_nxt  = addr_q;
    if (slot_free) begin
      state_nxt = issue ? WAIT : IDLE;
      if (issue) addr_nxt = fetch_pc_nxt;
    end else if (br_i) begin
      state_nxt = DROP;
    end
  end

  // A full buffer without a same-edge pop or flush blocks issue even if count math says otherwise.
  function automatic logic buf_full_after_flush(input logic full_now, input logic flush_now,
                                                input logic pop_now);
    return full_now && !flush_now && !pop_now;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= word_align(RESET_PC);
      addr_q   <= ZERO_WORD;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      addr_q   <= addr_nxt;
    end
  end

  // IF/ID register: a branch squashes to a zero bubble and outranks stall.
  always_ff @(posedge clk) begin
    if (rst || br_i) begin
      pc_q   <= ZERO_WORD;
      inst_q <= ZERO_WORD;
    end else if (!stall_i) begin
      if (!buf_empty) begin
        pc_q   <= head_pc;
        inst_q <= head_inst;
      end else begin
        inst_q <= ZERO_WORD;
      end
    end
  end

endmodule
